mac_feeder: RTL and testbench
=============================

# mac_feeder

Load-and-sequence controller that sits directly upstream of the MAC unit. It accepts a weight matrix, an input vector and per-row bias bytes over a valid/ready byte stream, then replays them as back-to-back MAC beats: `a`=weight, `b`=vector element, `x`=row bias, `mac_valid`. The MAC then produces one dot product per row, every `VEC_S` beats. The combination forms the matrix-vector front end of the neural-network datapath.

## Interface
- `VEC_S`, 3: vector length, i.e. MAC beats per row; must equal the MAC's `VEC_S`.
- `NUM_ROWS`, 2: matrix rows, i.e. dot products per run; ≥1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `in_data` input 8: signed load byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: feeder accepts a byte this cycle.
- `a` output 8 signed: weight to MAC.
- `b` output 8 signed: vector element to MAC.
- `x` output 8 unsigned: row bias to MAC.
- `mac_valid` output 1: drives MAC `valid_in`.
- `busy` output 1: high during RUN.
- `done` output 1: one-cycle pulse after the last beat of a run.

## Operation
- States: LOAD_W, LOAD_V, LOAD_B, RUN, DONE. State is held in a register.
- A byte transfers on any rising edge where `in_valid & in_ready`.
- LOAD_W:
  - Accepts `NUM_ROWS*VEC_S` weights, row-major (row 0 elements 0..VEC_S-1 first).
  - After the last weight, go to LOAD_V.
- LOAD_V: accepts `VEC_S` vector elements; after the last one, go to LOAD_B.
- LOAD_B:
  - Accepts `NUM_ROWS` bias bytes. Raw bits are stored and later presented unsigned on `x`.
  - After the last bias, go to RUN.
- RUN:
  - Issues exactly `NUM_ROWS*VEC_S` beats on consecutive cycles, with no gaps.
  - Beat (r,k) drives `a`=W[r][k], `b`=V[k], `x`=B[r], `mac_valid`=1. k is inner.
  - After the last beat, go to DONE.
- DONE: `done`=1 for one cycle, then return to LOAD_W. All storage must be reloaded; there is no reuse of old contents.
- Counters:
  - Element counter `k` runs 0..VEC_S-1.
  - Row counter `r` runs 0..NUM_ROWS-1.
  - Both clear on every state change and wrap `k` to 0 while incrementing `r`.
  - Widths are `$clog2` of (count+1).
- `in_ready` = 1 in LOAD_* states and 0 in RUN/DONE. It is decoded from the registered state only, with no combinational path from `in_valid`.
- `in_valid` while `in_ready`=0 is ignored and the data is dropped.
- `in_valid` low mid-load: the counters hold; there is no timeout.
- `a`, `b`, `x` hold their last value when `mac_valid`=0.
- Reset asserted (at any time, including mid-run):
  - Immediately clears state to LOAD_W and clears all counters.
  - Immediately forces `mac_valid`, `busy`, `done` to 0 and `a`, `b`, `x` to 0.
  - Clears storage.
  - A partially issued row is abandoned; the MAC is reset by the same net.

## Timing
- Reset values: `in_ready`=1 (LOAD_W), `mac_valid`=0, `busy`=0, `done`=0, `a`=`b`=`x`=0.
- All outputs are registered.
- The last bias is accepted at edge T. Then:
  - State is RUN after T.
  - The first beat appears after edge T+1.
  - The last beat appears after edge T+NUM_ROWS*VEC_S.
  - `done`=1 after edge T+NUM_ROWS*VEC_S+1.
  - `in_ready`=1 again after edge T+NUM_ROWS*VEC_S+2.
- `busy`=1 from the edge entering RUN through the cycle of the last beat.
- Throughput: one byte per cycle on load, one beat per cycle on run.
- Minimum run period: `NUM_ROWS*VEC_S + VEC_S + NUM_ROWS` load cycles + `NUM_ROWS*VEC_S` beats + 2.

## Structure
- Shared package `mac_pkg` holds:
  - `feed_state_t` enum (LOAD_W, LOAD_V, LOAD_B, RUN, DONE).
  - The data-width localparam `DATA_W`=8.
- One natural sub-module: `mac_feed_regfile`.
  - Holds the W, V and B arrays.
  - Has a write port selected by state/index and combinational read by (r,k).
  - Uses the same async active-low reset.
- Top level contains the FSM, counters and output registers.

## Test plan
- **Basic run**
  - Stimulus: `VEC_S`=3, `NUM_ROWS`=2. Load W=[1,2,3,-4,5,-6], V=[7,8,9], B=[10,20], with `in_valid` continuous.
  - Required beats, (a,b,x) on 6 consecutive cycles: (1,7,10),(2,8,10),(3,9,10),(-4,7,20),(5,8,20),(-6,9,20).
  - Then `done` pulses once.
  - With the MAC attached, MAC results are 60 and -22.
- **Load gaps**
  - Stimulus: the same data with `in_valid` toggling 1,0,1,0.
  - Required: identical beat sequence; the count of accepted bytes equals the count of `in_valid` high cycles.
- **Backpressure**
  - Stimulus: hold `in_valid`=1 with data 0x55 during RUN/DONE.
  - Required: `in_ready`=0 throughout; no storage change; the next load starts clean.
- **Reset mid-run**
  - Stimulus: drive `reset`=0 asynchronously during beat 3.
  - Required: `mac_valid`=0 and `busy`=0 immediately, no further beats, `in_ready`=1 after release.
- **Back-to-back runs with extremes**
  - Stimulus: W all -128, V all -128, B=255; then a second run with W=V=127, B=0.
  - Required: beats present exactly these values (`x`=255 unsigned), and `done` pulses once per run.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC feeder datapath.
package mac_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    LOAD_W = 3'd0,
    LOAD_V = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } feed_state_t;

  function automatic logic is_load(input feed_state_t s);
    return (s == LOAD_W) || (s == LOAD_V) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/mac_feed_regfile.sv
// Weight, vector and bias storage for the MAC feeder.
// One write port steered by load state, combinational read by (r,k).
module mac_feed_regfile
  import mac_pkg::*;
#(
  parameter int VEC_S    = 3,
  parameter int NUM_ROWS = 2,
  parameter int K_W      = 2,
  parameter int R_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  feed_state_t       wsel,
  input  logic [R_W-1:0]    r,
  input  logic [K_W-1:0]    k,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] w,
  output logic [DATA_W-1:0] v,
  output logic [DATA_W-1:0] bias
);

  localparam int IDX_W = $clog2(NUM_ROWS * VEC_S + 1);

  // Arrays are sized to the full index range so every index is in bounds.
  logic [DATA_W-1:0] w_mem_r [2**IDX_W];
  logic [DATA_W-1:0] v_mem_r [2**K_W];
  logic [DATA_W-1:0] b_mem_r [2**R_W];
  logic [IDX_W-1:0]  idx_s;

  assign idx_s = IDX_W'(int'(r) * VEC_S + int'(k));

  // Storage write port; reset wipes all contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**IDX_W; i++) w_mem_r[i] <= '0;
      for (int i = 0; i < 2**K_W; i++)   v_mem_r[i] <= '0;
      for (int i = 0; i < 2**R_W; i++)   b_mem_r[i] <= '0;
    end else if (we) begin
      case (wsel)
        LOAD_W:  w_mem_r[idx_s] <= wdata;
        LOAD_V:  v_mem_r[k]     <= wdata;
        LOAD_B:  b_mem_r[r]     <= wdata;
        default: ;
      endcase
    end
  end

  assign w    = w_mem_r[idx_s];
  assign v    = v_mem_r[k];
  assign bias = b_mem_r[r];

endmodule

// File: rtl/mac_feeder.sv
// Load-and-sequence controller feeding weight/vector/bias beats to the MAC.
// FSM, shared (r,k) counters and registered outputs live here.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int VEC_S    = 3,
  parameter int NUM_ROWS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] b,
  output logic        [DATA_W-1:0] x,
  output logic                     mac_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int K_W = $clog2(VEC_S + 1);
  localparam int R_W = $clog2(NUM_ROWS + 1);

  feed_state_t       state_r, state_nxt_s;
  logic [K_W-1:0]    k_r, k_nxt_s;
  logic [R_W-1:0]    r_r, r_nxt_s;
  logic              in_ready_r, busy_r, done_r, mac_valid_r;
  logic [DATA_W-1:0] a_r, b_r, x_r;
  logic [DATA_W-1:0] w_rd_s, v_rd_s, b_rd_s;
  logic              accept_s, k_last_s, r_last_s;

  assign accept_s = in_valid & in_ready_r;
  assign k_last_s = (k_r == K_W'(VEC_S - 1));
  assign r_last_s = (r_r == R_W'(NUM_ROWS - 1));

  mac_feed_regfile #(
    .VEC_S    (VEC_S),
    .NUM_ROWS (NUM_ROWS),
    .K_W      (K_W),
    .R_W      (R_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (accept_s),
    .wsel  (state_r),
    .r     (r_r),
    .k     (k_r),
    .wdata (in_data),
    .w     (w_rd_s),
    .v     (v_rd_s),
    .bias  (b_rd_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD_W:  if (accept_s && k_last_s && r_last_s) state_nxt_s = LOAD_V; else state_nxt_s = LOAD_W;
      LOAD_V:  if (accept_s && k_last_s) state_nxt_s = LOAD_B; else state_nxt_s = LOAD_V;
      LOAD_B:  if (accept_s && r_last_s) state_nxt_s = RUN; else state_nxt_s = LOAD_B;
      RUN:     if (k_last_s && r_last_s) state_nxt_s = DONE; else state_nxt_s = RUN;
      DONE:    state_nxt_s = LOAD_W;
      default: state_nxt_s = LOAD_W;
    endcase
  end

  // Counter update: bias load steps r only, other phases step k with row carry.
  always_comb begin
    k_nxt_s = k_r;
    r_nxt_s = r_r;
    if (state_nxt_s != state_r) begin
      k_nxt_s = '0;
      r_nxt_s = '0;
    end else if (state_r == LOAD_B) begin
      if (accept_s) r_nxt_s = r_r + R_W'(1);
      else          r_nxt_s = r_r;
    end else if (accept_s || (state_r == RUN)) begin
      if (k_last_s) begin
        k_nxt_s = '0;
        r_nxt_s = r_r + R_W'(1);
      end else begin
        k_nxt_s = k_r + K_W'(1);
      end
    end else begin
      k_nxt_s = k_r;
      r_nxt_s = r_r;
    end
  end

  // State, counters and output registers; beat data holds while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= LOAD_W;
      k_r         <= '0;
      r_r         <= '0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mac_valid_r <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      x_r         <= '0;
    end else begin
      state_r     <= state_nxt_s;
      k_r         <= k_nxt_s;
      r_r         <= r_nxt_s;
      // Ready only while staying in load, so it never opens into RUN/DONE.
      in_ready_r  <= is_load(state_r) & is_load(state_nxt_s);
      busy_r      <= (state_r == RUN) | (state_nxt_s == RUN);
      done_r      <= (state_r == DONE);
      mac_valid_r <= (state_r == RUN);
      if (state_r == RUN) begin
        a_r <= w_rd_s;
        b_r <= v_rd_s;
        x_r <= b_rd_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign mac_valid = mac_valid_r;
  assign a         = a_r;
  assign b         = b_r;
  assign x         = x_r;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed, table-driven bench for mac_feeder (VEC_S=3, NUM_ROWS=2).
module tb_mac_feeder;

  typedef struct packed {
    logic [5:0][7:0] w;
    logic [2:0][7:0] v;
    logic [1:0][7:0] bias;
    logic            gaps;
    logic            bp;
    logic [5:0][7:0] ea;
    logic [5:0][7:0] eb;
    logic [5:0][7:0] ex;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, x;
  logic       mac_valid, busy, done;

  int   vec_cnt  = 0;
  int   miscmp   = 0;
  vec_t tbl [5];

  mac_feeder #(.VEC_S(3), .NUM_ROWS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .x         (x),
    .mac_valid (mac_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [5:0][7:0] w, input logic [2:0][7:0] v,
                              input logic [1:0][7:0] bias, input logic gaps, input logic bp,
                              input logic [5:0][7:0] ea, input logic [5:0][7:0] eb,
                              input logic [5:0][7:0] ex);
    vec_t t;
    t.w = w; t.v = v; t.bias = bias; t.gaps = gaps; t.bp = bp;
    t.ea = ea; t.eb = eb; t.ex = ex;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Streams W, V, B of one record; returns just after the edge accepting the last bias.
  task automatic load_run(input int rec);
    logic [7:0] seq [11];
    int idx   = 0;
    int high  = 0;
    int acc   = 0;
    int guard = 0;
    bit ph    = 1'b0;
    for (int i = 0; i < 6; i++) seq[i]     = tbl[rec].w[i];
    for (int i = 0; i < 3; i++) seq[6 + i] = tbl[rec].v[i];
    for (int i = 0; i < 2; i++) seq[9 + i] = tbl[rec].bias[i];
    while (idx < 11 && guard < 200) begin
      guard++;
      if (tbl[rec].gaps && ph) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = seq[idx];
        high++;
      end
      ph = ~ph;
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc++;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("load_complete", idx, 11);
    check("accepted_eq_valid_cycles", acc, high);
  endtask

  // Checks the beat train, done pulse and in_ready return timing.
  task automatic run_check(input int rec);
    in_valid = tbl[rec].bp;
    in_data  = 8'h55;
    @(negedge clk);
    check("run_entry_in_ready", in_ready, 1'b0);
    check("run_entry_busy", busy, 1'b1);
    check("run_entry_mac_valid", mac_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("beat_mac_valid", mac_valid, 1'b1);
      check("beat_a", a, tbl[rec].ea[i]);
      check("beat_b", b, tbl[rec].eb[i]);
      check("beat_x", x, tbl[rec].ex[i]);
      check("beat_busy", busy, 1'b1);
      check("beat_in_ready", in_ready, 1'b0);
      check("beat_done", done, 1'b0);
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("done_mac_valid", mac_valid, 1'b0);
    check("done_busy", busy, 1'b0);
    check("done_in_ready", in_ready, 1'b0);
    check("done_a_hold", a, tbl[rec].ea[5]);
    @(negedge clk);
    check("post_done_low", done, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_mac_valid", mac_valid, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = mk({8'hFA, 8'h05, 8'hFC, 8'h03, 8'h02, 8'h01}, {8'h09, 8'h08, 8'h07},
                {8'h14, 8'h0A}, 1'b0, 1'b0,
                {8'hFA, 8'h05, 8'hFC, 8'h03, 8'h02, 8'h01},
                {8'h09, 8'h08, 8'h07, 8'h09, 8'h08, 8'h07},
                {8'h14, 8'h14, 8'h14, 8'h0A, 8'h0A, 8'h0A});
    tbl[1] = tbl[0];
    tbl[1].gaps = 1'b1;
    tbl[1].bp   = 1'b1;
    tbl[2] = tbl[0];
    tbl[3] = mk({6{8'h80}}, {3{8'h80}}, {2{8'hFF}}, 1'b0, 1'b0,
                {6{8'h80}}, {6{8'h80}}, {6{8'hFF}});
    tbl[4] = mk({6{8'h7F}}, {3{8'h7F}}, {2{8'h00}}, 1'b0, 1'b0,
                {6{8'h7F}}, {6{8'h7F}}, {6{8'h00}});

    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_mac_valid", mac_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_abx", {a, b, x}, 24'h000000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      load_run(t);
      run_check(t);
    end

    // Reset asserted asynchronously while the third beat is on the outputs.
    load_run(0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrun_rst_mac_valid", mac_valid, 1'b0);
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_abx", {a, b, x}, 24'h000000);
    check("midrun_rst_in_ready", in_ready, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("in_rst_mac_valid", mac_valid, 1'b0);
      check("in_rst_done", done, 1'b0);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_mac_valid", mac_valid, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    @(posedge clk);
    #1;
    load_run(2);
    run_check(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
